// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: waits MEM_WAIT cycles per address, captures the word and
// holds it for decode until a handshake or a redirect moves the pc on.
//
// state | meaning
// FETCH | address driven, wcnt counting down to the memory sample point
// HOLD  | captured instruction presented to decode (if_valid=1)
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WAIT  = 1,
    parameter int          MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_oor
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [3:0]  WAIT_INIT = 4'(MEM_WAIT - 1);
    localparam logic [31:0] WORDS     = 32'(MEM_WORDS);

    state_t      state;
    logic [31:0] pc;
    logic [3:0]  wcnt;
    logic        oor_now;

    assign imem_addr   = pc;
    assign if_pc_plus4 = if_pc + 32'd4;
    assign oor_now     = ({2'b00, pc[31:2]} >= WORDS);

    // Redirect outranks everything but reset; any in-flight fetch is simply
    // abandoned because the wait counter restarts on the new address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            state    <= FETCH;
            wcnt     <= WAIT_INIT;
            if_valid <= 1'b0;
            if_instr <= 32'h0;
            if_pc    <= 32'h0;
            if_oor   <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & 32'hFFFF_FFFC;
            state    <= FETCH;
            wcnt     <= WAIT_INIT;
            if_valid <= 1'b0;
        end else if (state == FETCH) begin
            if (wcnt == 4'd0) begin
                if_instr <= oor_now ? 32'h0 : imem_instr;
                if_pc    <= pc;
                if_oor   <= oor_now;
                state    <= HOLD;
                if_valid <= 1'b1;
            end else begin
                wcnt <= wcnt - 4'd1;
            end
        end else if (if_ready) begin
            pc       <= pc + 32'd4;
            state    <= FETCH;
            wcnt     <= WAIT_INIT;
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; a scoreboard queue holds the
// expected instruction stream and a monitor pops it on every handshake.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready, if_oor;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    logic [31:0] imem_addr3, imem_instr3, if_instr3, if_pc3, if_pc_plus4_3;
    logic        if_valid3, if_oor3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        oor;
    } exp_t;
    exp_t sb[$];

    localparam logic [31:0] WA = 32'h1000_0000;
    localparam logic [31:0] WB = 32'h1000_0001;
    localparam logic [31:0] WC = 32'h1000_0002;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if ((a >> 2) < 32'd1024) return 32'h1000_0000 + (a >> 2);
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_instr  = mem_rd(imem_addr);
    assign imem_instr3 = mem_rd(imem_addr3);

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_oor(if_oor)
    );

    instruction_fetch_unit #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr3), .imem_instr(imem_instr3),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_valid(if_valid3), .if_ready(1'b1), .if_instr(if_instr3),
        .if_pc(if_pc3), .if_pc_plus4(if_pc_plus4_3), .if_oor(if_oor3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input logic [31:0] pc, input logic [31:0] instr, input logic oor);
        exp_t e;
        e.pc = pc; e.instr = instr; e.oor = oor;
        sb.push_back(e);
    endfunction

    // Monitor: a handshake completes at the coming edge whenever valid&&ready now.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %h instr %h expected none", if_pc, if_instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hs_pc", if_pc, e.pc);
                check("hs_instr", if_instr, e.instr);
                check("hs_oor", {31'h0, if_oor}, {31'h0, e.oor});
                check("hs_pc_plus4", if_pc_plus4, e.pc + 32'd4);
            end
        end
    end

    initial begin
        rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_oor", {31'h0, if_oor}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // Straight-line stream A,B,C; valid every second cycle; dut3 shows latency 3
        rst_n = 1'b1; if_ready = 1'b1;
        push(32'h0, WA, 1'b0); push(32'h4, WB, 1'b0); push(32'h8, WC, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stream_valid", {31'h0, if_valid}, (i % 2 == 0) ? 32'h1 : 32'h0);
            check("w3_valid", {31'h0, if_valid3}, (i == 2) ? 32'h1 : 32'h0);
            if (i == 2) begin
                check("w3_pc", if_pc3, 32'h0);
                check("w3_instr", if_instr3, WA);
            end
        end

        // Redirect back to 4, then stall decode for 5 cycles
        redirect_valid = 1'b1; redirect_pc = 32'h4; if_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_valid", {31'h0, if_valid}, 32'h1);
            check("stall_instr", if_instr, WB);
            check("stall_pc", if_pc, 32'h4);
            check("stall_addr", imem_addr, 32'h4);
        end
        push(32'h4, WB, 1'b0);
        if_ready = 1'b1;
        tick();
        check("post_stall_addr", imem_addr, 32'h8);

        // Redirect in FETCH to misaligned 0x13: fetch at 8 is discarded
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
        tick();
        redirect_valid = 1'b0;
        check("redir_align_addr", imem_addr, 32'h10);
        push(32'h10, 32'h1000_0004, 1'b0);
        tick(); tick();

        // Wrap at the top of the address space; out-of-range word reads as 0
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        push(32'hFFFF_FFFC, 32'h0, 1'b1);
        push(32'h0, WA, 1'b0);
        tick(); tick();
        check("wrap_addr", imem_addr, 32'h0);
        tick(); tick();
        tick();
        check("hold_at_4", {31'h0, if_valid}, 32'h1);

        // Redirect with if_ready=1 in HOLD consumes the held word
        push(32'h4, WB, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0; if_ready = 1'b0;
        check("redir_hs_addr", imem_addr, 32'h20);
        check("redir_hs_valid", {31'h0, if_valid}, 32'h0);
        tick();
        check("hold20_valid", {31'h0, if_valid}, 32'h1);
        check("hold20_pc", if_pc, 32'h20);

        // Redirect with if_ready=0 drops the word without a handshake
        redirect_valid = 1'b1; redirect_pc = 32'h30;
        tick();
        redirect_valid = 1'b0;
        check("redir_drop_valid", {31'h0, if_valid}, 32'h0);
        check("redir_drop_addr", imem_addr, 32'h30);
        tick();

        // Reset beats redirect while holding
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        check("rst_hold_valid", {31'h0, if_valid}, 32'h0);
        check("rst_hold_addr", imem_addr, 32'h0);
        check("rst_hold_pc", if_pc, 32'h0);
        check("rst_hold_instr", if_instr, 32'h0);
        rst_n = 1'b1; redirect_valid = 1'b0; if_ready = 1'b1;
        push(32'h0, WA, 1'b0);
        tick(); tick();
        if_ready = 1'b0;
        tick(); tick();
        check("sb_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-002 SHALL have parameter MEM_WAIT, default 1; clock cycles between the imem_addr change and imem_instr sampling, legal range 1..15.
REQ-003 SHALL have parameter MEM_WORDS, default 1024; instruction memory depth in 32-bit words.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port imem_addr  output  32  byte address to the instruction memory.
REQ-007 SHALL have port imem_instr  input  32  instruction word returned by memory, valid MEM_WAIT cycles after an address change.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request, single-cycle.
REQ-009 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-010 SHALL have port if_valid  output  1  fetched instruction available to decode.
REQ-011 SHALL have port if_ready  input  1  decode accepts the instruction.
REQ-012 SHALL have port if_instr  output  32  captured instruction word.
REQ-013 SHALL have port if_pc  output  32  address of if_instr.
REQ-014 SHALL have port if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
REQ-015 SHALL have port if_oor  output  1  if_pc word index >= MEM_WORDS; if_instr is then 32'h0.

Function
REQ-016 SHALL hold the fetch address in register pc; imem_addr SHALL equal pc combinationally.
REQ-017 SHALL implement states FETCH and HOLD with wait counter wcnt (4 bits).
REQ-018 On entry to FETCH, wcnt SHALL load MEM_WAIT-1 and decrement each cycle; when wcnt==0 in FETCH, imem_instr (or 0 if out of range) SHALL be captured into if_instr, pc into if_pc, and the next state SHALL be HOLD.
REQ-019 if_valid SHALL be 1 exactly while in HOLD; fetch-to-valid latency SHALL be MEM_WAIT cycles after the entry to FETCH.
REQ-020 In HOLD, if_instr/if_pc/if_oor SHALL stay stable until if_valid && if_ready.
REQ-021 On handshake (HOLD, if_ready=1, no redirect): pc <= pc+4 modulo 2^32, next state FETCH.
REQ-022 redirect_valid SHALL have priority over the normal flow in any state: pc <= {redirect_pc[31:2],2'b00}, next state FETCH, wcnt reload, any in-flight fetch discarded.
REQ-023 Redirect in HOLD with if_ready=1 SHALL count as a completed handshake; the held instruction is consumed and the next fetch is from the redirect target.
REQ-024 Redirect in HOLD with if_ready=0 SHALL drop if_valid the next cycle without a handshake.
REQ-025 pc wrap: pc=32'hFFFF_FFFC plus 4 SHALL give 32'h0000_0000.
REQ-026 if_oor SHALL be computed from the captured pc as (pc>>2) >= MEM_WORDS.
REQ-027 Back-to-back throughput SHALL be one instruction per MEM_WAIT+1 cycles with if_ready held at 1.

Reset
REQ-028 When rst_n=0 at a rising edge: pc=RESET_PC, state=FETCH, wcnt=MEM_WAIT-1, if_valid=0, if_instr=0, if_pc=0, if_oor=0.
REQ-029 Reset SHALL override redirect and handshake in the same cycle; reset mid-HOLD SHALL drop if_valid on the next edge.

Verification
REQ-030 Reset, MEM_WAIT=1, memory words 0..2 = A,B,C, if_ready=1 -> if_pc 0,4,8 with if_instr A,B,C; if_valid high every 2nd cycle.
REQ-031 if_ready=0 for 5 cycles in HOLD at pc=4 -> if_instr=B and if_pc=4 stable; imem_addr stays 4; the next fetch address is 8 after if_ready rises.
REQ-032 redirect_valid with redirect_pc=32'h0000_0013 during FETCH -> the next if_pc=32'h10; the old fetch is never presented.
REQ-033 Redirect to 32'hFFFF_FFFC, two handshakes -> if_pc FFFF_FFFC then 0000_0000; first if_oor=1 with if_instr=0, second if_oor=0.
REQ-034 rst_n=0 while in HOLD with redirect_valid=1 -> the next cycle has if_valid=0 and imem_addr=RESET_PC.
